// File: rtl/ni_pkg.sv
// Shared network-interface definitions: flit and credit field layout plus arbiter states.
// Flit layout, MSB first: {valid, tail, dest, vc, data}; credit layout: {valid, vc}.
package ni_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  function automatic int flit_width(input int data_w, input int dest_w, input int vc_w);
    return 2 + dest_w + vc_w + data_w;
  endfunction

  function automatic int flit_vc_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int flit_dest_lsb(input int data_w, input int vc_w);
    return data_w + vc_w;
  endfunction

  function automatic int flit_tail_pos(input int data_w, input int dest_w, input int vc_w);
    return data_w + vc_w + dest_w;
  endfunction

  function automatic int flit_valid_pos(input int data_w, input int dest_w, input int vc_w);
    return flit_tail_pos(data_w, dest_w, vc_w) + 1;
  endfunction

  function automatic int credit_width(input int vc_w);
    return 1 + vc_w;
  endfunction

endpackage

// File: rtl/ni_vc_fifo.sv
// Single-VC circular FIFO with occupancy count; pointers wrap modulo DEPTH (a power of two).
module ni_vc_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push   = push && (!full || pop);
  assign do_pop    = pop && !empty;
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/flit_recv_ni.sv
// Receive-side network interface: per-VC flit buffering, packet-atomic round-robin output, credit return.
// Optional macro NI_DEST_CHECK_EN drops flits whose dest differs from MY_PORT and flags dest_err.
module flit_recv_ni
  import ni_pkg::*;
#(
  parameter int FLIT_DATA_WIDTH = 64,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int NUM_VCS         = 2,
  parameter int DEPTH           = 4,
  parameter int MY_PORT         = 1
) (
  input  logic                                                   CLK,
  input  logic                                                   RST_N,
  input  logic [flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS)-1:0] flit_in,
  output logic [credit_width(VC_BITS)-1:0]                       credit_out,
  output logic                                                   credit_en,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [FLIT_DATA_WIDTH-1:0]                             out_data,
  output logic                                                   out_tail,
  output logic [VC_BITS-1:0]                                     out_vc,
  output logic                                                   overflow,
  output logic                                                   dest_err
);

  localparam int VALID_POS = flit_valid_pos(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS);
  localparam int TAIL_POS  = flit_tail_pos(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS);
  localparam int DEST_LSB  = flit_dest_lsb(FLIT_DATA_WIDTH, VC_BITS);
  localparam int VC_LSB    = flit_vc_lsb(FLIT_DATA_WIDTH);
  localparam int EW        = FLIT_DATA_WIDTH + 1;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int NSLOT     = 1 << VC_BITS;

  logic                       in_valid;
  logic                       in_tail;
  logic [VC_BITS-1:0]         in_vc;
  logic [FLIT_DATA_WIDTH-1:0] in_data;
  logic                       vc_ok;
  logic                       dest_ok;
  logic                       do_pop;
  logic [VC_BITS-1:0]         rr_ptr;
  logic [VC_BITS-1:0]         held_vc;
  logic [VC_BITS-1:0]         arb_vc;
  logic [VC_BITS-1:0]         sel_vc;
  logic [NUM_VCS-1:0]         vc_hit;
  logic [NUM_VCS-1:0]         push;
  logic [NUM_VCS-1:0]         pop;
  logic [NUM_VCS-1:0]         full;
  logic [NUM_VCS-1:0]         empty;
  logic [NUM_VCS-1:0]         ovf_vec;
  logic [EW-1:0]              head [NUM_VCS];
  logic [CW-1:0]              count [NUM_VCS];
  logic [NSLOT-1:0]           occupied;
  logic [NSLOT-1:0]           empty_slot;
  logic [EW-1:0]              head_slot [NSLOT];
  arb_state_e                 state;

  assign in_valid = flit_in[VALID_POS];
  assign in_tail  = flit_in[TAIL_POS];
  assign in_vc    = flit_in[VC_LSB +: VC_BITS];
  assign in_data  = flit_in[FLIT_DATA_WIDTH-1:0];
  assign vc_ok    = ({1'b0, in_vc} < (VC_BITS + 1)'(NUM_VCS));

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign vc_hit[v]  = in_valid && vc_ok && (in_vc == VC_BITS'(v));
    assign push[v]    = vc_hit[v] && dest_ok && (!full[v] || pop[v]);
    assign ovf_vec[v] = vc_hit[v] && dest_ok && full[v] && !pop[v];
    assign pop[v]     = do_pop && (sel_vc == VC_BITS'(v));

    ni_vc_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push[v]),
      .push_data ({in_tail, in_data}),
      .pop       (pop[v]),
      .head_data (head[v]),
      .count     (count[v]),
      .full      (full[v]),
      .empty     (empty[v])
    );
  end

  // Pad per-VC status to the full VC index space so unused indices read as empty.
  always_comb begin
    occupied   = '0;
    empty_slot = '1;
    for (int i = 0; i < NSLOT; i++) head_slot[i] = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      occupied[v]   = (count[v] != '0);
      empty_slot[v] = empty[v];
      head_slot[v]  = head[v];
    end
  end

  // Descending scan so the first occupied VC at or after rr_ptr wins.
  always_comb begin
    arb_vc = rr_ptr;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (occupied[rr_ptr + VC_BITS'(i)]) arb_vc = rr_ptr + VC_BITS'(i);
    end
  end

  assign sel_vc                = (state == ARB_LOCKED) ? held_vc : arb_vc;
  assign out_valid             = !empty_slot[sel_vc];
  assign {out_tail, out_data}  = head_slot[sel_vc];
  assign out_vc                = sel_vc;
  assign do_pop                = out_valid && out_ready;

  // Lock onto a VC while its flit is stalled or its packet is unfinished; release after the tail.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ARB_IDLE;
      held_vc <= '0;
      rr_ptr  <= '0;
    end else if (do_pop) begin
      if (out_tail) begin
        state  <= ARB_IDLE;
        rr_ptr <= sel_vc + 1'b1;
      end else begin
        state   <= ARB_LOCKED;
        held_vc <= sel_vc;
      end
    end else if (out_valid) begin
      state   <= ARB_LOCKED;
      held_vc <= sel_vc;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      overflow <= 1'b0;
    end else if ((|ovf_vec) || (in_valid && !vc_ok)) begin
      overflow <= 1'b1;
    end
  end

`ifdef NI_DEST_CHECK_EN
  logic [DEST_BITS-1:0] in_dest;
  logic                 drop_now;
  logic                 pend_any;
  logic [VC_BITS-1:0]   pend_vc;
  logic [CW-1:0]        pend_cnt [NUM_VCS];

  assign in_dest  = flit_in[DEST_LSB +: DEST_BITS];
  assign dest_ok  = (in_dest == DEST_BITS'(MY_PORT));
  assign drop_now = in_valid && vc_ok && !dest_ok;

  always_comb begin
    pend_any = 1'b0;
    pend_vc  = '0;
    for (int v = NUM_VCS - 1; v >= 0; v--) begin
      if (pend_cnt[v] != '0) begin
        pend_any = 1'b1;
        pend_vc  = VC_BITS'(v);
      end
    end
  end

  // A dropped flit whose credit collides with a pop credit is remembered and returned later.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int v = 0; v < NUM_VCS; v++) pend_cnt[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (drop_now && do_pop && (in_vc == VC_BITS'(v)))
          pend_cnt[v] <= pend_cnt[v] + 1'b1;
        else if (!do_pop && !drop_now && pend_any && (pend_vc == VC_BITS'(v)))
          pend_cnt[v] <= pend_cnt[v] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        dest_err <= 1'b0;
    else if (drop_now) dest_err <= 1'b1;
  end
`else
  assign dest_ok  = 1'b1;
  assign dest_err = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      credit_en  <= 1'b0;
      credit_out <= '0;
    end else begin
      credit_en  <= 1'b0;
      credit_out <= '0;
      if (do_pop) begin
        credit_en  <= 1'b1;
        credit_out <= {1'b1, sel_vc};
      end
`ifdef NI_DEST_CHECK_EN
      else if (drop_now) begin
        credit_en  <= 1'b1;
        credit_out <= {1'b1, in_vc};
      end else if (pend_any) begin
        credit_en  <= 1'b1;
        credit_out <= {1'b1, pend_vc};
      end
`endif
    end
  end

endmodule

// File: tb/tb_flit_recv_ni.sv
// Scoreboard bench for flit_recv_ni: directed flits queue expected outputs; a monitor checks pops and credits.
module tb_flit_recv_ni;

  localparam int DW  = 64;
  localparam int DB  = 2;
  localparam int VB  = 1;
  localparam int MP  = 1;
  localparam int FW  = 2 + DB + VB + DW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          tail;
    logic [VB-1:0] vc;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [FW-1:0] flit_in;
  logic [VB:0]   credit_out;
  logic          credit_en;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_tail;
  logic [VB-1:0] out_vc;
  logic          overflow;
  logic          dest_err;

  int            assert_count = 0;
  int            fail_count   = 0;
  exp_t          exp_q [$];
  logic          cred_exp_valid = 1'b0;
  logic [VB-1:0] cred_exp_vc    = '0;
  logic          drop_sent      = 1'b0;
  logic [VB-1:0] drop_vc        = '0;

  flit_recv_ni #(
    .FLIT_DATA_WIDTH (DW),
    .DEST_BITS       (DB),
    .VC_BITS         (VB),
    .NUM_VCS         (2),
    .DEPTH           (4),
    .MY_PORT         (MP)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .flit_in    (flit_in),
    .credit_out (credit_out),
    .credit_en  (credit_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tail   (out_tail),
    .out_vc     (out_vc),
    .overflow   (overflow),
    .dest_err   (dest_err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic tail, input logic [DB-1:0] dest, input logic [VB-1:0] vc,
                               input logic [DW-1:0] data, input bit expect_out);
    @(posedge CLK); #1;
    flit_in = {1'b1, tail, dest, vc, data};
    if (expect_out) exp_q.push_back('{data: data, tail: tail, vc: vc});
  endtask

  task automatic pushExp(input logic tail, input logic [VB-1:0] vc, input logic [DW-1:0] data);
    exp_q.push_back('{data: data, tail: tail, vc: vc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
      flit_in = '0;
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
    idle(2);
  endtask

  // Monitor: verify the credit owed from last cycle, then score any flit popped this cycle.
  always @(negedge CLK) begin
    if (!RST_N) begin
      cred_exp_valid = 1'b0;
      drop_sent      = 1'b0;
    end else begin
      if (cred_exp_valid) begin
        checkOutput("credit_en", credit_en, 1);
        checkOutput("credit_out", credit_out, {1'b1, cred_exp_vc});
      end else begin
        checkOutput("credit_idle", {credit_en, credit_out}, 0);
      end
      cred_exp_valid = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL unexpected_flit: got data 0x%0h vc %0d, required no flit", out_data, out_vc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_tail", out_tail, e.tail);
          checkOutput("out_vc", out_vc, e.vc);
          cred_exp_valid = 1'b1;
          cred_exp_vc    = e.vc;
        end
      end else if (drop_sent) begin
        cred_exp_valid = 1'b1;
        cred_exp_vc    = drop_vc;
        drop_sent      = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    RST_N     = 1'b1;
    out_ready = 1'b0;
    flit_in   = '0;
    #1 RST_N  = 1'b0;
    #11;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_credit_en", credit_en, 0);
    checkOutput("rst_credit_out", credit_out, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkOutput("rst_dest_err", dest_err, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    $display("[TB] single flit");
    out_ready = 1'b1;
    applyStimulus(1'b1, MP, 0, 64'h1234, 1'b1);
    idle(1);
    @(negedge CLK);
    checkOutput("t1_latency_valid", out_valid, 1);
    checkOutput("t1_latency_data", out_data, 64'h1234);
    @(negedge CLK);
    checkOutput("t1_credit_en", credit_en, 1);
    checkOutput("t1_credit_out", credit_out, 2'b10);
    waitDrain("t1_drain", 10);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(i == 3, MP, 1, 64'hA0 + 64'(i), 1'b1);
    idle(2);
    @(negedge CLK);
    checkOutput("t2_no_overflow", overflow, 0);
    checkOutput("t2_hold_valid", out_valid, 1);
    checkOutput("t2_hold_data_a", out_data, 64'hA0);
    @(negedge CLK);
    checkOutput("t2_hold_data_b", out_data, 64'hA0);
    checkOutput("t2_hold_vc", out_vc, 1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    waitDrain("t2_drain", 20);

    $display("[TB] overflow");
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, MP, 0, 64'hB0 + 64'(i), i < 4);
    idle(2);
    @(negedge CLK);
    checkOutput("t3_overflow", overflow, 1);
    @(posedge CLK); #1;
    out_ready = 1'b1;
    waitDrain("t3_drain", 20);

    $display("[TB] interleaved packets");
    pushExp(1'b0, 0, 64'hC0);
    pushExp(1'b0, 0, 64'hC1);
    pushExp(1'b1, 0, 64'hC2);
    pushExp(1'b0, 1, 64'hD0);
    pushExp(1'b1, 1, 64'hD1);
    applyStimulus(1'b0, MP, 0, 64'hC0, 1'b0);
    applyStimulus(1'b0, MP, 1, 64'hD0, 1'b0);
    applyStimulus(1'b0, MP, 0, 64'hC1, 1'b0);
    applyStimulus(1'b1, MP, 1, 64'hD1, 1'b0);
    applyStimulus(1'b1, MP, 0, 64'hC2, 1'b0);
    idle(1);
    waitDrain("t4_drain", 30);

    $display("[TB] dest check");
`ifdef NI_DEST_CHECK_EN
    applyStimulus(1'b1, 2'd3, 0, 64'hEE, 1'b0);
    drop_vc   = 0;
    drop_sent = 1'b1;
    idle(2);
    @(negedge CLK);
    checkOutput("t5_dest_err", dest_err, 1);
    checkOutput("t5_no_valid", out_valid, 0);
    idle(2);
`else
    applyStimulus(1'b1, 2'd3, 0, 64'hEE, 1'b1);
    idle(1);
    waitDrain("t5_drain", 10);
    checkOutput("t5_dest_err_off", dest_err, 0);
`endif

    $display("[TB] mid-operation reset");
    out_ready = 1'b0;
    applyStimulus(1'b0, MP, 0, 64'hF0, 1'b0);
    applyStimulus(1'b1, MP, 0, 64'hF1, 1'b0);
    idle(2);
    @(negedge CLK);
    checkOutput("t6_valid_before", out_valid, 1);
    checkOutput("t6_overflow_before", overflow, 1);
    @(posedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checkOutput("t6_rst_valid", out_valid, 0);
    checkOutput("t6_rst_credit_en", credit_en, 0);
    checkOutput("t6_rst_credit_out", credit_out, 0);
    checkOutput("t6_rst_overflow", overflow, 0);
    checkOutput("t6_rst_dest_err", dest_err, 0);
    @(posedge CLK); #1;
    RST_N     = 1'b1;
    out_ready = 1'b1;
    idle(5);
    @(negedge CLK);
    checkOutput("t6_no_stale", out_valid, 0);
    checkOutput("t6_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/flit_recv_ni.md
FLIT_RECV_NI -- requirements
Module: flit_recv_ni

Interface
REQ-001 SHALL have parameter FLIT_DATA_WIDTH, default 64, payload bits per flit.
REQ-002 SHALL have parameter DEST_BITS, default 2, width of the flit dest field.
REQ-003 SHALL have parameter VC_BITS, default 1, width of the VC field (1 even when NUM_VCS=1).
REQ-004 SHALL have parameter NUM_VCS, default 2, number of virtual channels buffered.
REQ-005 SHALL have parameter DEPTH, default 4, flit entries per VC; power of two, at least 2.
REQ-006 SHALL have parameter MY_PORT, default 1, this receive port's index.
REQ-007 SHALL have port CLK, input, 1, single clock; all state on rising edge.
REQ-008 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-009 SHALL have port flit_in, input, 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH, network flit {valid, tail, dest, vc, data}, MSB first.
REQ-010 SHALL have port credit_out, output, 1+VC_BITS, returned credit {valid, vc}.
REQ-011 SHALL have port credit_en, output, 1, enable for the network putCredits method.
REQ-012 SHALL have port out_valid, output, 1, a buffered flit is presented.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts the presented flit.
REQ-014 SHALL have port out_data, output, FLIT_DATA_WIDTH, payload of the presented flit.
REQ-015 SHALL have port out_tail, output, 1, tail bit of the presented flit.
REQ-016 SHALL have port out_vc, output, VC_BITS, VC of the presented flit.
REQ-017 SHALL have port overflow, output, 1, sticky: a flit arrived at a full VC.
REQ-018 SHALL have port dest_err, output, 1, sticky: a flit arrived with the wrong dest.

Function
REQ-019 SHALL accept flit_in into the FIFO selected by flit_in.vc on any cycle flit_in.valid=1; no accept handshake exists, since credits guarantee space.
REQ-020 SHALL present an accepted flit on out_* no earlier than the cycle after it arrives; with empty FIFOs and out_ready=1, latency is exactly 1 cycle.
REQ-021 SHALL pop one flit per cycle when out_valid and out_ready are both 1; out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 SHALL choose the presented VC by round-robin among non-empty VCs; the pointer advances past a VC only after a tail flit pops, so packets never interleave on out_*.
REQ-023 SHALL register one credit {1, vc} per popped flit, with credit_en=1 exactly one cycle after the pop; credit_en=0 and credit_out=0 otherwise.
REQ-024 SHALL accept a push to a full VC if that VC pops in the same cycle (count unchanged); otherwise it SHALL drop the flit, set overflow, and leave the FIFO unchanged.
REQ-025 SHALL ignore flits with an out-of-range vc (vc>=NUM_VCS) and SHALL set overflow for them.
REQ-026 SHALL handle read and write pointers modulo DEPTH, wrapping silently; each VC's count SHALL stay within 0..DEPTH.
REQ-027 SHALL treat a simultaneous push and pop on different VCs independently.

Reset
REQ-028 SHALL, on RST_N=0, asynchronously clear all FIFOs, pointers, the round-robin pointer, overflow and dest_err, and drive out_valid=0, credit_en=0 and credit_out=0.
REQ-029 SHALL discard in-flight flits and pending credits on a mid-operation reset; credits are not reissued, because the network resets its counters to DEPTH per VC.

Configuration
REQ-030 SHALL, with NI_DEST_CHECK_EN defined, compare flit_in.dest with MY_PORT and handle a mismatch as follows:
- drop the flit;
- set dest_err;
- still return one credit the following cycle.
REQ-031 SHALL, without NI_DEST_CHECK_EN, accept every flit regardless of dest, with dest_err tied to 0.

Structure
REQ-032 SHALL place the flit and credit field offsets and width functions in shared package ni_pkg, which flit_send_ni also uses.
REQ-033 SHALL use one sub-module, ni_vc_fifo (single-VC FIFO with count, full and empty), instantiated NUM_VCS times.

Verification
REQ-034 SHALL verify single flit: vc0, data=0x1234, tail=1, out_ready=1 -> out_valid one cycle later with data 0x1234, then credit_en=1 with credit_out={1,0} one cycle after the pop.
REQ-035 SHALL verify backpressure: 4 flits on vc1 with out_ready=0 -> no overflow and no credits; then out_ready=1 -> 4 pops in order and 4 credits {1,1} on consecutive cycles.
REQ-036 SHALL verify overflow: 5 flits on vc0 with out_ready=0 -> overflow=1 and exactly the first 4 delivered.
REQ-037 SHALL verify interleaving: a 3-flit packet on vc0 and a 2-flit packet on vc1 arriving interleaved -> out_* delivers all vc0 flits through the tail, then vc1, never mixed.
REQ-038 SHALL verify the dest check: with NI_DEST_CHECK_EN, a flit with dest=3 at MY_PORT=1 -> dest_err=1, no out_valid, one credit returned.
REQ-039 SHALL verify mid-operation reset: RST_N low while 2 flits are buffered -> out_valid, credit_en and the sticky flags are 0 immediately, and no stale flit appears after release.
